// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed seven-segment scanner with frame-synchronous shadow buffer
module seg_scan_ctrl #(
    parameter int DIGITS = 16,
    parameter int DIV    = 10000,
    parameter int DEAD   = 16,
    parameter int BR_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  lz_suppress,
    input  logic [BR_W-1:0]       brightness,
    output logic [DIGITS-1:0]     seg_sel_n,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = $clog2(DIGITS);
    localparam int STEP = (DIV - DEAD) >> BR_W;
    localparam logic [31:0] DEAD_U = 32'(DEAD);
    localparam logic [31:0] STEP_U = 32'(STEP);

    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          c_wrap;
    logic          boundary;

    logic [4*DIGITS-1:0] act_data, pend_data;
    logic [DIGITS-1:0]   act_dp, pend_dp;
    logic [DIGITS-1:0]   act_blank, pend_blank;
    logic                pend_valid;
    logic                xfer;

    logic [31:0]       c_ext;
    logic [31:0]       win_len;
    logic              in_window;
    logic [3:0]        nib;
    logic [DIGITS-1:0] nonzero;
    logic              suppressed;
    logic [DIGITS-1:0] sel_nxt;
    logic [7:0]        seg_nxt;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] r;
        case (n)
            4'h0: r = 7'h40;
            4'h1: r = 7'h79;
            4'h2: r = 7'h24;
            4'h3: r = 7'h30;
            4'h4: r = 7'h19;
            4'h5: r = 7'h12;
            4'h6: r = 7'h02;
            4'h7: r = 7'h78;
            4'h8: r = 7'h00;
            4'h9: r = 7'h10;
            4'hA: r = 7'h08;
            4'hB: r = 7'h03;
            4'hC: r = 7'h46;
            4'hD: r = 7'h21;
            4'hE: r = 7'h06;
            default: r = 7'h0E;
        endcase
        return r;
    endfunction

    assign c_wrap     = (c == CW'(DIV - 1));
    assign boundary   = c_wrap && (d == DW'(DIGITS - 1));
    assign load_ready = ~pend_valid;
    assign xfer       = load_valid && ~pend_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c <= '0;
            d <= '0;
        end else begin
            c <= c_wrap ? '0 : c + CW'(1);
            if (c_wrap)
                d <= (d == DW'(DIGITS - 1)) ? '0 : d + DW'(1);
        end
    end

    // Pending can only be refilled once it has been committed, so commit and
    // capture never coincide on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
        end else if (boundary && pend_valid) begin
            act_data   <= pend_data;
            act_dp     <= pend_dp;
            act_blank  <= pend_blank;
            pend_valid <= 1'b0;
        end else if (xfer) begin
            pend_data  <= data_in;
            pend_dp    <= dp_in;
            pend_blank <= blank_in;
            pend_valid <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < DIGITS; i++)
            nonzero[i] = |act_data[4*i +: 4];
    end

    always_comb begin
        c_ext      = 32'(c);
        win_len    = STEP_U * (32'(brightness) + 32'd1);
        in_window  = (c_ext >= DEAD_U) && ((c_ext - DEAD_U) < win_len);
        nib        = act_data[{d, 2'b00} +: 4];
        // Digit d is a leading zero when it and every higher nibble are zero.
        suppressed = lz_suppress && (d != '0) && ((nonzero >> d) == '0);
    end

    always_comb begin
        sel_nxt = '1;
        seg_nxt = 8'hFF;
        if (in_window && !act_blank[d]) begin
            sel_nxt[d]   = 1'b0;
            seg_nxt[7]   = ~act_dp[d];
            seg_nxt[6:0] = suppressed ? 7'h7F : decode(nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_sel_n  <= '1;
            seg        <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            seg_sel_n  <= sel_nxt;
            seg        <= seg_nxt;
            frame_done <= boundary;
        end
    end

endmodule
